// File: rtl/eeg_xram_rd_ctrl.sv
// rtl/eeg_xram_rd_ctrl.sv - strided burst-read initiator for one XRAM bank port
// Address issue is credit-limited so returned data always finds room in the FIFO.
module eeg_xram_rd_ctrl #(
  parameter int XRAM_ADD_AW = 12,
  parameter int XRAM_DAT_DW = 8,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   CMD_VLD,
  output logic                   CMD_RDY,
  input  logic [XRAM_ADD_AW-1:0] CMD_BASE,
  input  logic [XRAM_ADD_AW-1:0] CMD_LEN,
  input  logic [XRAM_ADD_AW-1:0] CMD_STRIDE,
  output logic                   XRAM_ADD_VLD,
  output logic                   XRAM_ADD_LST,
  input  logic                   XRAM_ADD_RDY,
  output logic [XRAM_ADD_AW-1:0] XRAM_ADD_ADD,
  input  logic                   XRAM_DAT_VLD,
  input  logic                   XRAM_DAT_LST,
  output logic                   XRAM_DAT_RDY,
  input  logic [XRAM_DAT_DW-1:0] XRAM_DAT_DAT,
  output logic                   OUT_VLD,
  output logic                   OUT_LST,
  input  logic                   OUT_RDY,
  output logic [XRAM_DAT_DW-1:0] OUT_DAT,
  output logic                   BUSY,
  output logic                   DONE
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1) + 1;
  localparam int EW = XRAM_DAT_DW + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [XRAM_ADD_AW-1:0] addr_q, addr_d;
  logic [XRAM_ADD_AW-1:0] cnt_q, cnt_d;
  logic [XRAM_ADD_AW-1:0] len_q, len_d;
  logic [XRAM_ADD_AW-1:0] stride_q, stride_d;
  logic [CW-1:0]          outs_q, outs_d;
  logic [CW-1:0]          fcnt_q, fcnt_d;
  logic [PW-1:0]          wptr_q, wptr_d;
  logic [PW-1:0]          rptr_q, rptr_d;
  logic                   done_q, done_d;
  logic [EW-1:0]          mem_q [FIFO_DEPTH];

  logic [CW-1:0] credits;
  logic          cmd_hs;
  logic          add_vld;
  logic          add_hs;
  logic          add_lst;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          pop;
  logic          last_pop;
  logic [EW-1:0] head;

  // Pops do not return credits until the count register updates.
  assign credits    = outs_q + fcnt_q;
  assign cmd_hs     = CMD_VLD && (state_q == S_IDLE);
  assign add_vld    = (state_q == S_ISSUE) && (credits < CW'(FIFO_DEPTH));
  assign add_lst    = (state_q == S_ISSUE) && (cnt_q == len_q);
  assign add_hs     = add_vld && XRAM_ADD_RDY;
  assign fifo_full  = (fcnt_q == CW'(FIFO_DEPTH));
  assign fifo_empty = (fcnt_q == '0);
  // Data with no outstanding request (e.g. in flight across a reset) is dropped.
  assign push       = XRAM_DAT_VLD && !fifo_full && (outs_q != '0);
  assign pop        = !fifo_empty && OUT_RDY;
  assign head       = mem_q[rptr_q];
  assign last_pop   = pop && head[XRAM_DAT_DW];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(FIFO_DEPTH - 1)) return '0;
    return p + PW'(1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (cmd_hs) state_d = S_ISSUE;
      S_ISSUE: if (add_hs && add_lst) state_d = S_DRAIN;
      S_DRAIN: if (last_pop) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    CMD_RDY      = (state_q == S_IDLE);
    BUSY         = (state_q != S_IDLE);
    XRAM_ADD_VLD = add_vld;
    XRAM_ADD_LST = add_lst;
    XRAM_ADD_ADD = addr_q;
    XRAM_DAT_RDY = !fifo_full;
    OUT_VLD      = !fifo_empty;
    OUT_LST      = !fifo_empty && head[XRAM_DAT_DW];
    OUT_DAT      = fifo_empty ? '0 : head[XRAM_DAT_DW-1:0];
    DONE         = done_q;
  end

  always_comb begin
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    stride_d = stride_q;
    outs_d   = outs_q;
    fcnt_d   = fcnt_q;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    done_d   = last_pop;

    if (cmd_hs) begin
      addr_d   = CMD_BASE;
      cnt_d    = '0;
      len_d    = CMD_LEN;
      stride_d = CMD_STRIDE;
    end else if (add_hs) begin
      addr_d = addr_q + stride_q;
      cnt_d  = cnt_q + XRAM_ADD_AW'(1);
    end

    case ({add_hs, push})
      2'b10:   outs_d = outs_q + CW'(1);
      2'b01:   outs_d = outs_q - CW'(1);
      default: outs_d = outs_q;
    endcase

    case ({push, pop})
      2'b10:   fcnt_d = fcnt_q + CW'(1);
      2'b01:   fcnt_d = fcnt_q - CW'(1);
      default: fcnt_d = fcnt_q;
    endcase

    if (push) wptr_d = ptr_inc(wptr_q);
    if (pop)  rptr_d = ptr_inc(rptr_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q   <= '0;
      cnt_q    <= '0;
      len_q    <= '0;
      stride_q <= '0;
      outs_q   <= '0;
      fcnt_q   <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      stride_q <= stride_d;
      outs_q   <= outs_d;
      fcnt_q   <= fcnt_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      done_q   <= done_d;
    end
  end

  // Storage needs no reset: the outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= {XRAM_DAT_LST, XRAM_DAT_DAT};
  end

endmodule
